// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    END     = 2'd3
  } seq_state_t;

  localparam logic [15:0] LAST_ADDR_DEFAULT = 16'hBFFF;
  localparam int          MEM_LAT_MIN       = 1;
  localparam int          MEM_LAT_MAX       = 4;
  localparam int          WAIT_CNT_W        = 3;

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter; done marks the last cycle of a MEM_LAT-long wait.
module seq_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             run,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Read data is valid on the cycle the count reaches one, not zero.
  assign done = run && (count == CNT_W'(1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer driving the 16-bit program counter and program memory.
// Optional stall counter enabled by defining SEQ_STALL_COUNT_EN.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = LAST_ADDR_DEFAULT,
  parameter int                MEM_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_index,
  output logic              pc_enable,
  output logic              pc_inc_or_set,
  output logic [ADDR_W-1:0] pc_new_value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              branch_ack,
  output logic              branch_err,
  output logic              at_end,
  output logic [15:0]       stall_count
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("pc_fetch_sequencer: MEM_LAT out of range");
  end

  seq_state_t        state, state_next;
  logic              pend;
  logic [ADDR_W-1:0] pend_tgt;
  logic              branch_legal;
  logic              branch_bad;
  logic              timer_load;
  logic              timer_done;
  logic              capture;
  logic              consumed;

  assign branch_legal = branch_req && (branch_target <= LAST_ADDR);
  assign branch_bad   = branch_req && (branch_target >  LAST_ADDR);
  assign mem_addr     = pc_index;
  assign instr_valid  = (state == PRESENT);
  assign at_end       = (state == END);

  seq_wait_timer #(
    .CNT_W (WAIT_CNT_W)
  ) u_wait_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (WAIT_CNT_W'(MEM_LAT)),
    .run        (state == WAIT),
    .done       (timer_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_enable     = 1'b0;
    pc_inc_or_set = 1'b0;
    pc_new_value  = '0;
    branch_ack    = 1'b0;
    mem_rd_en     = 1'b0;
    timer_load    = 1'b0;
    capture       = 1'b0;
    consumed      = 1'b0;
    case (state)
      FETCH: begin
        mem_rd_en  = 1'b1;
        timer_load = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (timer_done) begin
          capture    = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (instr_ready) begin
          if (pend) begin
            pc_enable     = 1'b1;
            pc_inc_or_set = 1'b1;
            pc_new_value  = pend_tgt;
            branch_ack    = 1'b1;
            consumed      = 1'b1;
            state_next    = FETCH;
          end else if (pc_index == LAST_ADDR) begin
            state_next = END;
          end else begin
            pc_enable  = 1'b1;
            state_next = FETCH;
          end
        end
      end
      END: begin
        // A request arriving now is newer than any pending one, so it wins.
        if (branch_legal || pend) begin
          pc_enable     = 1'b1;
          pc_inc_or_set = 1'b1;
          pc_new_value  = branch_legal ? branch_target : pend_tgt;
          branch_ack    = 1'b1;
          consumed      = 1'b1;
          state_next    = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
    if (!reset) begin
      pc_enable     = 1'b0;
      pc_inc_or_set = 1'b0;
      pc_new_value  = '0;
      branch_ack    = 1'b0;
      mem_rd_en     = 1'b0;
      timer_load    = 1'b0;
      capture       = 1'b0;
      consumed      = 1'b0;
    end
  end

  // The handoff consumes the old target; a same-cycle request becomes the new one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend       <= 1'b0;
      pend_tgt   <= '0;
      branch_err <= 1'b0;
    end else begin
      branch_err <= branch_bad;
      if (consumed) begin
        pend <= 1'b0;
      end
      if (branch_legal && (state != END)) begin
        pend     <= 1'b1;
        pend_tgt <= branch_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_data <= '0;
      instr_addr <= '0;
    end else if (capture) begin
      instr_data <= mem_rdata;
      instr_addr <= pc_index;
    end
  end

`ifdef SEQ_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (instr_valid && !instr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer with a counter/memory environment
// and a cycle-budget reference model.
module tb_pc_fetch_sequencer;

  localparam int          MEM_LAT = 1;
  localparam logic [15:0] LAST    = 16'hBFFF;
`ifdef SEQ_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_index;
  logic        pc_enable;
  logic        pc_inc_or_set;
  logic [15:0] pc_new_value;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [15:0] instr_addr;
  logic        branch_req = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        branch_ack;
  logic        branch_err;
  logic        at_end;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  pc_fetch_sequencer #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .LAST_ADDR (LAST),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_index      (pc_index),
    .pc_enable     (pc_enable),
    .pc_inc_or_set (pc_inc_or_set),
    .pc_new_value  (pc_new_value),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .branch_ack    (branch_ack),
    .branch_err    (branch_err),
    .at_end        (at_end),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  // The program counter being driven, and a fixed-latency program memory.
  logic [15:0] pc = 16'h0;
  logic [15:0] rd_pipe [MEM_LAT];
  assign pc_index  = pc;
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  always @(posedge clock) begin
    if (!reset) pc <= 16'h0;
    else if (pc_enable) pc <= pc_inc_or_set ? pc_new_value : pc + 16'd1;
  end

  always @(posedge clock) begin
    rd_pipe[0] <= mem_rd_en ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each word is due MEM_LAT+2 cycles after the previous
  // counter update (or reset), and is handed off by the spec's priority rules.
  int          wait_left = MEM_LAT + 1;
  logic        halted    = 1'b0;
  logic        was_halted;
  logic        pend      = 1'b0;
  logic [15:0] pend_tgt  = 16'h0;
  logic [15:0] exp_addr  = 16'h0;
  logic        exp_err   = 1'b0;
  int          stall_m   = 0;
  logic        after_reset = 1'b0;
  logic        ev, hand, legal, set_exp, inc_exp;
  logic [15:0] set_val;

  always @(negedge clock) begin
    if (!reset) begin
      exp_addr    = 16'h0;
      pend        = 1'b0;
      halted      = 1'b0;
      wait_left   = MEM_LAT + 1;
      exp_err     = 1'b0;
      stall_m     = 0;
      after_reset = 1'b1;
    end else begin
      was_halted = halted;
      legal = branch_req && (branch_target <= LAST);
      ev    = !halted && (wait_left == 0);
      if (after_reset) begin
        checkOutput("rst_data", 32'(instr_data), 32'h0);
        checkOutput("rst_addr", 32'(instr_addr), 32'h0);
        after_reset = 1'b0;
      end
      checkOutput("valid", 32'(instr_valid), 32'(ev));
      checkOutput("at_end", 32'(at_end), 32'(halted));
      checkOutput("rd_en", 32'(mem_rd_en), 32'(!halted && (wait_left == MEM_LAT + 1)));
      if (!halted && (wait_left == MEM_LAT + 1))
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
      checkOutput("err", 32'(branch_err), 32'(exp_err));
      checkOutput("stall", 32'(stall_count), STALL_EN ? 32'(stall_m) : 32'h0);
      if (ev) begin
        checkOutput("iaddr", 32'(instr_addr), 32'(exp_addr));
        checkOutput("idata", 32'(instr_data), 32'(exp_addr ^ 16'hA5A5));
      end
      hand    = ev && instr_ready;
      set_exp = 1'b0;
      set_val = 16'h0;
      if (halted) begin
        if (legal) begin set_exp = 1'b1; set_val = branch_target; end
        else if (pend) begin set_exp = 1'b1; set_val = pend_tgt; end
      end else if (hand && pend) begin
        set_exp = 1'b1;
        set_val = pend_tgt;
      end
      inc_exp = hand && !pend && (exp_addr != LAST);
      checkOutput("pc_en", 32'(pc_enable), 32'(set_exp || inc_exp));
      checkOutput("ack", 32'(branch_ack), 32'(set_exp));
      if (set_exp) begin
        checkOutput("set", 32'(pc_inc_or_set), 32'h1);
        checkOutput("newval", 32'(pc_new_value), 32'(set_val));
      end
      if (inc_exp) checkOutput("inc", 32'(pc_inc_or_set), 32'h0);

      if (ev && !instr_ready && stall_m != 65535) stall_m++;
      exp_err = branch_req && (branch_target > LAST);
      if (set_exp) begin
        pend      = 1'b0;
        exp_addr  = set_val;
        wait_left = MEM_LAT + 1;
        halted    = 1'b0;
      end else if (inc_exp) begin
        exp_addr  = exp_addr + 16'd1;
        wait_left = MEM_LAT + 1;
      end else if (hand) begin
        halted = 1'b1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (legal && !was_halted) begin
        pend     = 1'b1;
        pend_tgt = branch_target;
      end
    end
  end

  // Drive one setting for a number of cycles; the branch request is a single pulse.
  task automatic applyStimulus(input logic rst_n, input logic rdy, input logic breq,
                               input logic [15:0] tgt, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      reset         = rst_n;
      instr_ready   = rdy;
      branch_req    = (i == 0) ? breq : 1'b0;
      branch_target = tgt;
      @(posedge clock);
      #1;
    end
  endtask

  logic [15:0] rtgt;
  logic        rrst, rrdy, rreq;

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 10);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0100, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hC000, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hBFFE, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 14);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0200, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 8);

    for (int n = 0; n < 4000; n++) begin
      rrst = ($urandom_range(0, 399) != 0);
      rrdy = ($urandom_range(0, 3) != 0);
      rreq = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rtgt = 16'($urandom_range(16'hC000, 16'hFFFF));
        1:       rtgt = 16'($urandom_range(16'hBFF0, 16'hBFFF));
        default: rtgt = 16'($urandom_range(0, 16'h0FFF));
      endcase
      applyStimulus(rrst, rrdy, rreq, rtgt, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Control-side partner of the 16-bit program counter. Drives the counter's enable/incOrSet/newValue inputs, reads program memory at the counter's index, and presents each fetched word downstream with a valid/ready handshake. Also accepts branch (set) requests and stops at the last legal address 0xBFFF.

Parameters:
ADDR_W, 16, address/index width
DATA_W, 16, program word width
LAST_ADDR, 16'hBFFF, highest legal program address; fetch ends here
MEM_LAT, 1, memory read latency in cycles after mem_rd_en (legal 1..4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
pc_index  in  ADDR_W  current counter value
pc_enable  out  1  counter enable
pc_inc_or_set  out  1  0 = increment, 1 = load pc_new_value
pc_new_value  out  ADDR_W  load value for counter
mem_addr  out  ADDR_W  memory read address (combinational copy of pc_index)
mem_rd_en  out  1  one-cycle read strobe
mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_rd_en
instr_valid  out  1  fetched word available
instr_ready  in  1  downstream accepts word
instr_data  out  DATA_W  fetched word
instr_addr  out  ADDR_W  address of instr_data
branch_req  in  1  single-cycle branch request
branch_target  in  ADDR_W  branch destination
branch_ack  out  1  one-cycle pulse when target is loaded into counter
branch_err  out  1  one-cycle pulse when target > LAST_ADDR (request dropped)
at_end  out  1  high while halted at LAST_ADDR
stall_count  out  16  see Optional Feature

Behaviour:
- Reset is sampled on the clock edge with reset==0 → state FETCH; all outputs 0; pending branch cleared. The counter resets to 0 on the same edge.
- FETCH: mem_rd_en=1 for one cycle, mem_addr=pc_index → WAIT. Wait counter is loaded with MEM_LAT.
- WAIT: decrement the counter. On the cycle mem_rdata is valid (MEM_LAT cycles after the strobe), register instr_data<=mem_rdata and instr_addr<=pc_index → PRESENT.
- PRESENT: instr_valid=1; instr_data and instr_addr are held stable until accepted. On instr_valid&&instr_ready, priority is:
  (a) branch pending: pc_enable=1, pc_inc_or_set=1, pc_new_value=target, branch_ack=1, clear pending → FETCH;
  (b) else if pc_index==LAST_ADDR: no counter pulse → END;
  (c) else pc_enable=1, pc_inc_or_set=0 → FETCH.
- Counter controls are asserted only in the handoff cycle, so FETCH always sees the updated index.
- END: at_end=1, instr_valid=0. A pending or arriving branch applies the set (as in (a)) on that cycle → FETCH, at_end drops next cycle.
- Branch capture happens in any state:
  - If branch_target>LAST_ADDR: branch_err pulses next cycle; the request is ignored and any existing pending branch is kept.
  - Otherwise pending<=1 and target latched; a new request overwrites an older pending target (last wins).
  - A request in the same cycle as a handoff is latched and applies at the next handoff; the in-progress handoff uses the previously pending branch only.
- Latency: first instr_valid is 1+MEM_LAT cycles after reset release. With ready held high, throughput is one word per MEM_LAT+2 cycles.
- Reset mid-fetch: in-flight read data is discarded, instr_valid drops on the reset edge, and pending branch is cleared.

Optional Feature:
SEQ_STALL_COUNT_EN: when defined, stall_count increments (saturating at 16'hFFFF) on every cycle with instr_valid&&!instr_ready, and clears on reset. When undefined, stall_count is tied to 0 and no counter register exists.

Decomposition:
- Package pc_seq_pkg: state enum {FETCH, WAIT, PRESENT, END}, LAST_ADDR default constant, MEM_LAT legal-range constants.
- One sub-module, seq_wait_timer: loadable down-counter with a done flag, used for the MEM_LAT wait.

Test Plan:
- Reset, MEM_LAT=1, mem returns addr^16'hA5A5, ready=1 → words for addr 0,1,2 with instr_valid at cycles 2,5,8; pc_inc_or_set=0 at each handoff.
- Hold ready=0 for 5 cycles in PRESENT → instr_data/instr_addr stable, no pc_enable; with macro defined stall_count=5.
- branch_req target=16'h0100 during WAIT of addr 3 → word 3 delivered; next handoff pulses pc_enable with pc_inc_or_set=1 and new_value=16'h0100, plus branch_ack; next instr_addr=16'h0100.
- Branch target=16'hC000 → branch_err pulse, no ack, sequence continues incrementing.
- Branch to 16'hBFFE, accept 2 words → at_end=1 with no increment at 16'hBFFF; then branch to 16'h0010 → set applied, fetch resumes at 16'h0010.
- reset=0 asserted during WAIT → instr_valid=0, pending branch cleared, next fetch at addr 0.
